// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// Latency: none (declarations only). Backpressure: not applicable.
// State encodings 10/11 are only reachable when MAIN_CTRL_ADDI_EN is defined.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    MEM_ADDR   = 4'd2,
    MEM_READ   = 4'd3,
    MEM_WB     = 4'd4,
    MEM_WRITE  = 4'd5,
    EXECUTE    = 4'd6,
    R_COMPLETE = 4'd7,
    BRANCH     = 4'd8,
    JUMP       = 4'd9,
    ADDI_EXEC  = 4'd10,
    ADDI_WB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational map from (state, mem_ready) to the datapath control word.
// Latency: 0 cycles. Backpressure: mem_ready gates IRWrite/PCWrite in FETCH.
// Macro MAIN_CTRL_ADDI_EN enables the ADDI_EXEC/ADDI_WB decodes.
module main_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_COMPLETE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = 2'b00;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
`ifdef MAIN_CTRL_ADDI_EN
      ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath; macro MAIN_CTRL_ADDI_EN adds addi.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles; each mem_ready-low cycle in FETCH,
// MEM_READ or MEM_WRITE holds the state one more cycle.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUop,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [STATE_W-1:0] state,
  output logic               illegal_op
);

  state_t state_q, state_d;
  ctrl_t  ctrl, ctrl_g;
  logic   illegal_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      FETCH:     if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MAIN_CTRL_ADDI_EN
          OP_ADDI:      state_d = ADDI_EXEC;
`endif
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Op may only legally be lw/sw here; anything else abandons the access.
      MEM_ADDR: begin
        if (Op == OP_LW)      state_d = MEM_READ;
        else if (Op == OP_SW) state_d = MEM_WRITE;
        else                  state_d = FETCH;
      end
      MEM_READ:   if (mem_ready) state_d = MEM_WB;
      MEM_WRITE:  if (mem_ready) state_d = FETCH;
      EXECUTE:    state_d = R_COMPLETE;
`ifdef MAIN_CTRL_ADDI_EN
      ADDI_EXEC:  state_d = ADDI_WB;
`endif
      default:    state_d = FETCH;
    endcase
  end

  main_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Outputs are forced quiet while reset is held, even though state is FETCH.
  assign ctrl_g      = rst_n ? ctrl : '0;
  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign IorD        = ctrl_g.i_or_d;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign IRWrite     = ctrl_g.ir_write;
  assign PCSource    = ctrl_g.pc_source;
  assign ALUop       = ctrl_g.alu_op;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign ALUSrcB     = ctrl_g.alu_src_b;
  assign RegWrite    = ctrl_g.reg_write;
  assign RegDst      = ctrl_g.reg_dst;
  assign illegal_op  = rst_n & illegal_d;
  assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed-vector bench for multicycle_main_control with a queue scoreboard.
// Stimulus pushes one expected output word per cycle; the monitor pops and compares at negedge.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op = 6'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUop, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  logic [21:0] exp_q[$];
  string       name_q[$];
  logic        stim_done = 1'b0;

  always #5 clk = ~clk;

  multicycle_main_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUop(ALUop),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .illegal_op(illegal_op)
  );

  // Packing order: state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
  // IRWrite, PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op
  function automatic logic [21:0] mk(input logic [3:0] st, input logic pcw, pcwc, iord,
                                     mr, mw, m2r, irw, input logic [1:0] pcs, aop,
                                     input logic sa, input logic [1:0] sb,
                                     input logic rw, rd, ill);
    return {st, pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, sa, sb, rw, rd, ill};
  endfunction

  wire [21:0] act = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst,
                     illegal_op};

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin
    logic [21:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        tests++;
        if (act !== e) begin
          fails++;
          $display("FAIL %s: got %06h expected %06h", n, act, e);
        end
      end
    end
  end

  logic [21:0] E_RST, F1, F0, DEC, DEC_ILL, MADDR, MREAD, MWB, MWR, EXEC, RCOMP, BR, JMP;
  logic [21:0] AEX, AWB;

  task automatic step(input logic [5:0] op, input logic mr, input logic rst,
                      input logic [21:0] e, input string n);
    @(posedge clk);
    #1;
    Op        = op;
    mem_ready = mr;
    rst_n     = rst;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin
    //        st  pcw pcwc iord mr mw m2r irw pcs   aop   sa sb    rw rd ill
    E_RST   = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0);
    F1      = mk(0, 1, 0, 0, 1, 0, 0, 1, 2'd0, 2'd0, 0, 2'd1, 0, 0, 0);
    F0      = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd1, 0, 0, 0);
    DEC     = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd3, 0, 0, 0);
    DEC_ILL = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd3, 0, 0, 1);
    MADDR   = mk(2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 0, 0, 0);
    MREAD   = mk(3, 0, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0);
    MWB     = mk(4, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0, 2'd0, 1, 0, 0);
    MWR     = mk(5, 0, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0, 0);
    EXEC    = mk(6, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 1, 2'd0, 0, 0, 0);
    RCOMP   = mk(7, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 1, 1, 0);
    BR      = mk(8, 0, 1, 0, 0, 0, 0, 0, 2'd1, 2'd1, 1, 2'd0, 0, 0, 0);
    JMP     = mk(9, 1, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 2'd0, 0, 0, 0);
    AEX     = mk(10, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'd2, 0, 0, 0);
    AWB     = mk(11, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 1, 0, 0);

    // Reset held, then first FETCH cycle after release.
    step(6'b100011, 1'b1, 1'b0, E_RST, "reset_hold");
    step(6'b100011, 1'b1, 1'b1, F1,    "post_reset_fetch");

    // lw, zero wait states.
    step(6'b100011, 1'b1, 1'b1, DEC,   "lw_decode");
    step(6'b100011, 1'b1, 1'b1, MADDR, "lw_mem_addr");
    step(6'b100011, 1'b1, 1'b1, MREAD, "lw_mem_read");
    step(6'b100011, 1'b1, 1'b1, MWB,   "lw_mem_wb");

    // sw with two wait states in MEM_WRITE; fetch also waits once first.
    step(6'b101011, 1'b0, 1'b1, F0,    "sw_fetch_wait");
    step(6'b101011, 1'b1, 1'b1, F1,    "sw_fetch");
    step(6'b101011, 1'b0, 1'b1, DEC,   "sw_decode_ignores_ready");
    step(6'b101011, 1'b1, 1'b1, MADDR, "sw_mem_addr");
    step(6'b101011, 1'b0, 1'b1, MWR,   "sw_write_wait1");
    step(6'b101011, 1'b0, 1'b1, MWR,   "sw_write_wait2");
    step(6'b101011, 1'b1, 1'b1, MWR,   "sw_write_done");

    // R-type; Op changes in EXECUTE must not matter.
    step(6'b000000, 1'b1, 1'b1, F1,    "r_fetch");
    step(6'b000000, 1'b1, 1'b1, DEC,   "r_decode");
    step(6'b100011, 1'b1, 1'b1, EXEC,  "r_execute");
    step(6'b100011, 1'b1, 1'b1, RCOMP, "r_complete");

    // beq and j.
    step(6'b000100, 1'b1, 1'b1, F1,    "beq_fetch");
    step(6'b000100, 1'b1, 1'b1, DEC,   "beq_decode");
    step(6'b000100, 1'b1, 1'b1, BR,    "beq_branch");
    step(6'b000010, 1'b1, 1'b1, F1,    "j_fetch");
    step(6'b000010, 1'b1, 1'b1, DEC,   "j_decode");
    step(6'b000010, 1'b1, 1'b1, JMP,   "j_jump");

    // Unsupported opcode.
    step(6'b111111, 1'b1, 1'b1, F1,      "ill_fetch");
    step(6'b111111, 1'b1, 1'b1, DEC_ILL, "ill_decode");

    // addi: legal only with the optional feature.
    step(6'b001000, 1'b1, 1'b1, F1,    "addi_fetch");
`ifdef MAIN_CTRL_ADDI_EN
    step(6'b001000, 1'b1, 1'b1, DEC,   "addi_decode");
    step(6'b001000, 1'b1, 1'b1, AEX,   "addi_exec");
    step(6'b001000, 1'b1, 1'b1, AWB,   "addi_wb");
`else
    step(6'b001000, 1'b1, 1'b1, DEC_ILL, "addi_decode_illegal");
`endif

    // Reset asserted mid-MEM_WRITE kills the write at once.
    step(6'b101011, 1'b1, 1'b1, F1,    "rst_sw_fetch");
    step(6'b101011, 1'b1, 1'b1, DEC,   "rst_sw_decode");
    step(6'b101011, 1'b1, 1'b1, MADDR, "rst_sw_mem_addr");
    step(6'b101011, 1'b0, 1'b1, MWR,   "rst_sw_write_wait");
    step(6'b101011, 1'b0, 1'b0, E_RST, "rst_mid_write");
    step(6'b101011, 1'b1, 1'b1, F1,    "rst_release_fetch");
    step(6'b000010, 1'b1, 1'b1, DEC,   "rst_release_decode");

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences PC, instruction register, register file, memory port and ALU across the fetch, decode, execute, memory and write-back steps.
- Drives the 2-bit ALUop consumed by the ALU control decoder (00 add, 01 subtract, 10 use funct).
- Stalls in memory states until the memory signals ready.

Parameters:
- STATE_W, 4, state register width. Must hold 12 encodings.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Op  in  6  opcode field of the instruction register (IR[31:26])
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemtoReg  out  1  write-back data select: 1 = MDR
- IRWrite  out  1  instruction register load
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUop  out  2  to ALU control decoder
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2
- RegWrite  out  1  register file write
- RegDst  out  1  destination select: 1 = rd, 0 = rt
- state  out  STATE_W  current state, for debug
- illegal_op  out  1  unsupported opcode seen in DECODE

Behaviour:
- Reset: asynchronous on rst_n low.
  - state = FETCH (0).
  - While rst_n is low, every output is 0 except state = 0. MemRead is forced to 0 during reset.
  - After release, FETCH outputs apply from the first clock.
- Outputs decode combinationally from the state register. IRWrite, PCWrite and PCWriteCond additionally qualify on mem_ready where stated. Any output not listed for a state is 0.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000 (addi only with the optional feature).
- States, outputs and transitions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready. Goes to DECODE when mem_ready, otherwise holds.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUop=00.
    - Next state by Op: lw or sw -> MEM_ADDR; R-type -> EXECUTE; beq -> BRANCH; j -> JUMP; addi -> ADDI_EXEC.
    - Any other Op -> FETCH, with illegal_op=1 for this cycle.
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to MEM_READ if lw, MEM_WRITE if sw.
  - MEM_READ(3): MemRead=1, IorD=1. Goes to MEM_WB when mem_ready, otherwise holds.
  - MEM_WB(4): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
  - MEM_WRITE(5): MemWrite=1, IorD=1. Goes to FETCH when mem_ready, otherwise holds.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUop=10. Goes to R_COMPLETE.
  - R_COMPLETE(7): RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
  - JUMP(9): PCWrite=1, PCSource=10. Goes to FETCH.
  - ADDI_EXEC(10): ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to ADDI_WB.
  - ADDI_WB(11): RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
  - Encodings 12-15: all outputs 0, next state FETCH.
- Latency with zero wait states, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Op is sampled only in DECODE and MEM_ADDR. Op changing in other states has no effect.
- Reset asserted mid-instruction returns to FETCH immediately. No partial write completes after the reset edge.
- mem_ready is ignored in states that do not access memory.

Optional Feature:
- Macro: MAIN_CTRL_ADDI_EN.
- Defined: addi is decoded and ADDI_EXEC and ADDI_WB exist as specified.
- Undefined: opcode 001000 is illegal (DECODE -> FETCH, illegal_op=1). States 10 and 11 are treated as unused encodings.

Decomposition:
- Shared package mips_ctrl_pkg:
  - State localparams FETCH..ADDI_WB.
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - ALUop constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
- One sub-module, main_ctrl_outdec: a purely combinational map from (state, mem_ready) to all control outputs.
- The top module keeps the state register and the next-state logic.

Test Plan:
- Reset with rst_n=0 mid-MEM_WRITE -> state=0 and MemWrite=0 immediately. After release with mem_ready=1: MemRead=1, ALUSrcB=01, IRWrite=1, PCWrite=1.
- lw (Op=100011), mem_ready always 1 -> states 0,1,2,3,4,0. MemtoReg=1 and RegWrite=1 in cycle 5 only.
- sw (Op=101011), mem_ready low for 2 cycles in MEM_WRITE -> MemWrite=1 and IorD=1 for 3 cycles, then FETCH. RegWrite is never 1.
- R-type (Op=000000) -> ALUop=10 in EXECUTE. RegDst=1 and RegWrite=1 in R_COMPLETE. Total 4 cycles.
- beq (Op=000100) -> BRANCH shows ALUop=01, PCWriteCond=1, PCSource=01. j (Op=000010) -> JUMP shows PCWrite=1, PCSource=10.
- Op=001000 with the macro undefined -> illegal_op=1 for 1 cycle in DECODE, then FETCH. With MAIN_CTRL_ADDI_EN defined -> states 10,11, ALUSrcB=10, then RegWrite=1 and RegDst=0.
